// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the pipeline skid register: state encoding and the
// NOP instruction word driven whenever no entry is held.
package riscv_pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      MAIN  = 2'b01,
      SKID  = 2'b10
   } skid_state_e;

   // ADD x0,x0,x0
   localparam logic [31:0] NOP_INSN = 32'h0000_0033;

   function automatic logic [1:0] state_occupancy(input skid_state_e s);
      logic [1:0] occ;
      occ = 2'd0;
      case (s)
         MAIN:    occ = 2'd1;
         SKID:    occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// N-bit payload slot with load enable and asynchronous reset to a fixed value.
module pipe_data_reg #(
   parameter int             N         = 32,
   parameter logic [N-1:0]   RST_VALUE = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld_i,
   input  logic [N-1:0] d_i,
   output logic [N-1:0] q_o
);

   logic [N-1:0] data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       data_q <= RST_VALUE;
      else if (ld_i) data_q <= d_i;
   end

   assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer between pipeline stages. in_ready is a flop so the
// upstream handshake never sees a combinational path from out_ready.
module pipe_skid_reg
   import riscv_pipe_pkg::*;
#(
   parameter int           N         = 32,
   parameter logic [N-1:0] NOP_VALUE = N'(NOP_INSN)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic [1:0]   occupancy
);

   skid_state_e  state_q, state_d;
   logic         in_ready_q;
   logic         accept, release_w;
   logic         ld_main, ld_skid, main_from_skid;
   logic [N-1:0] main_d, main_q, skid_q;

   assign accept    = in_valid & in_ready_q & ~flush;
   assign release_w = out_valid & out_ready;

   always_comb begin
      state_d        = state_q;
      ld_main        = 1'b0;
      ld_skid        = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         // slots keep their contents; only the state forgets them
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = MAIN;
                  ld_main = 1'b1;
               end
            end
            MAIN: begin
               if (accept && release_w) begin
                  ld_main = 1'b1;
               end else if (accept) begin
                  state_d = SKID;
                  ld_skid = 1'b1;
               end else if (release_w) begin
                  state_d = EMPTY;
               end
            end
            SKID: begin
               if (release_w) begin
                  state_d        = MAIN;
                  ld_main        = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   assign main_d = main_from_skid ? skid_q : in_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != SKID);
      end
   end

   pipe_data_reg #(.N(N), .RST_VALUE(NOP_VALUE)) u_main (
      .clk  (clk),
      .rst  (rst),
      .ld_i (ld_main),
      .d_i  (main_d),
      .q_o  (main_q)
   );

   pipe_data_reg #(.N(N), .RST_VALUE(NOP_VALUE)) u_skid (
      .clk  (clk),
      .rst  (rst),
      .ld_i (ld_skid),
      .d_i  (in_data),
      .q_o  (skid_q)
   );

   // Mask the main slot so released or flushed data never leaks out.
   assign out_valid = (state_q != EMPTY);
   assign out_data  = out_valid ? main_q : NOP_VALUE;
   assign in_ready  = in_ready_q;
   assign occupancy = state_occupancy(state_q);

endmodule
